// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet blocks: state encoding,
// default stream geometry and the ceiling-log2 helper.
package axis_pkg;

    localparam int C_AXIS_TDATA_WIDTH_DEF = 32;
    localparam int MAX_PKT_WORDS_DEF      = 16;

    typedef enum logic {
        PASS    = 1'b0,
        TRAILER = 1'b1
    } state_t;

    // Ceiling log2; clogb2(16) = 4, clogb2(17) = 5.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_pkt_checksum.sv
// Forwards AXI-Stream payload words through a one-beat output register and
// appends a trailer word holding the 32-bit modular sum of each packet.
module axis_pkt_checksum
    import axis_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = C_AXIS_TDATA_WIDTH_DEF,
    parameter int MAX_PKT_WORDS      = MAX_PKT_WORDS_DEF,
    localparam int LEN_W             = clogb2(MAX_PKT_WORDS) + 1,
    localparam int STRB_W            = C_AXIS_TDATA_WIDTH / 8
) (
    input  logic                          axis_aclk,
    input  logic                          axis_areset,

    input  logic                          s00_axis_tvalid,
    output logic                          s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic [STRB_W-1:0]             s00_axis_tstrb,
    input  logic                          s00_axis_tlast,

    output logic                          m00_axis_tvalid,
    input  logic                          m00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic [STRB_W-1:0]             m00_axis_tstrb,
    output logic                          m00_axis_tlast,

    output logic                          pkt_done,
    output logic [LEN_W-1:0]              pkt_len,
    output logic [C_AXIS_TDATA_WIDTH-1:0] pkt_sum
);

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic [C_AXIS_TDATA_WIDTH-1:0]   r_sum;
    logic [LEN_W-1:0]                r_count;

    logic                            r_m_tvalid;
    logic [C_AXIS_TDATA_WIDTH-1:0]   r_m_tdata;
    logic                            r_m_tlast;

    logic                            r_pkt_done;
    logic [LEN_W-1:0]                r_pkt_len;
    logic [C_AXIS_TDATA_WIDTH-1:0]   r_pkt_sum;

    logic                            w_free;
    logic                            w_s_tready;
    logic                            w_accept;
    logic                            w_at_max;
    logic                            w_end_of_payload;
    logic                            w_unused_tstrb;

    // Byte strobes carry no information here; every byte is treated valid.
    assign w_unused_tstrb   = ^s00_axis_tstrb;

    assign w_free           = !r_m_tvalid || m00_axis_tready;
    assign w_s_tready       = !axis_areset && (r_state == PASS) && w_free;
    assign w_accept         = s00_axis_tvalid && w_s_tready;
    assign w_at_max         = (r_count == LEN_W'(MAX_PKT_WORDS - 1));
    assign w_end_of_payload = w_accept && (s00_axis_tlast || w_at_max);

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_state <= PASS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PASS: begin
                if (w_end_of_payload) begin
                    w_state_nxt = TRAILER;
                end
            end
            TRAILER: begin
                if (w_free) begin
                    w_state_nxt = PASS;
                end
            end
            default: w_state_nxt = PASS;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_sum      <= '0;
            r_count    <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_pkt_done <= 1'b0;
            r_pkt_len  <= '0;
            r_pkt_sum  <= '0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                PASS: begin
                    if (w_accept) begin
                        r_m_tdata  <= s00_axis_tdata;
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= 1'b0;
                        r_sum      <= r_sum + s00_axis_tdata;
                        r_count    <= r_count + LEN_W'(1);
                    end else if (w_free) begin
                        r_m_tvalid <= 1'b0;
                    end
                end
                TRAILER: begin
                    // r_sum already includes the final payload word here.
                    if (w_free) begin
                        r_m_tdata  <= r_sum;
                        r_m_tlast  <= 1'b1;
                        r_m_tvalid <= 1'b1;
                        r_pkt_done <= 1'b1;
                        r_pkt_len  <= r_count;
                        r_pkt_sum  <= r_sum;
                        r_sum      <= '0;
                        r_count    <= '0;
                    end
                end
                default: begin
                    r_m_tvalid <= 1'b0;
                end
            endcase
        end
    end

    assign s00_axis_tready = w_s_tready;
    assign m00_axis_tvalid = r_m_tvalid;
    assign m00_axis_tdata  = r_m_tdata;
    assign m00_axis_tlast  = r_m_tlast;
    assign m00_axis_tstrb  = '1;
    assign pkt_done        = r_pkt_done;
    assign pkt_len         = r_pkt_len;
    assign pkt_sum         = r_pkt_sum;

endmodule
